// File: rtl/hazard_scheduler_pkg.sv
// Shared types and constants for the hazard scheduler: register index width,
// forward-select encoding, shadow-pipeline entry layout and the source-match rule.
package hazard_scheduler_pkg;

  localparam int unsigned REG_W          = 5;
  localparam int unsigned MD_W           = 6;
  localparam int unsigned MUL_CYCLES_DEF = 4;
  localparam int unsigned DIV_CYCLES_DEF = 32;

  typedef enum logic {
    FWD_SEL_MEM = 1'b0,
    FWD_SEL_WB  = 1'b1
  } fwd_sel_e;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
    logic     writes;
    logic     is_load;
  } shadow_t;

  localparam shadow_t SHADOW_EMPTY = '0;

  // $0 is hardwired, so it never creates a dependency.
  function automatic logic src_match(input shadow_t e, input reg_idx_t s, input logic uses);
    return e.valid & e.writes & (e.dest == s) & (s != '0) & uses;
  endfunction

endpackage

// File: rtl/hazard_scheduler_muldiv_timer.sv
// Multiply/divide latency timer: loads the operation latency on acceptance,
// counts down to zero, and keeps counting while the pipeline is frozen.
module muldiv_timer
  import hazard_scheduler_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [MD_W-1:0] MUL_LOAD = MD_W'(MUL_CYCLES);
  localparam logic [MD_W-1:0] DIV_LOAD = MD_W'(DIV_CYCLES);

  logic [MD_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? DIV_LOAD : MUL_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard controller: shadow EX/MEM destination tracking, registered
// EX-stage forward selects, load-use and HI/LO stalls, branch flush bubbles.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idValid,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUsesRs,
  input  logic       idUsesRt,
  input  logic [4:0] idDest,
  input  logic       idWrites,
  input  logic       idIsLoad,
  input  logic       idIsMul,
  input  logic       idIsDiv,
  input  logic       idReadsHiLo,
  input  logic       exFlush,
  input  logic       memStall,
  output logic       stallF,
  output logic       bubbleE,
  output logic       rsFwd,
  output logic       rtFwd,
  output logic       rsFwdSel,
  output logic       rtFwdSel,
  output logic       mdBusy
);

  shadow_t ent_e;
  shadow_t ent_m;

  logic rs_e, rt_e, rs_m, rt_m;
  logic load_use, hilo_wait;
  logic issue, md_start, md_busy;

  assign rs_e = src_match(ent_e, idRs, idUsesRs);
  assign rt_e = src_match(ent_e, idRt, idUsesRt);
  assign rs_m = src_match(ent_m, idRs, idUsesRs);
  assign rt_m = src_match(ent_m, idRt, idUsesRt);

  assign load_use  = idValid & ent_e.is_load & (rs_e | rt_e);
  assign hilo_wait = idValid & (idReadsHiLo | idIsMul | idIsDiv) & md_busy;

  // Flush wins over everything; a frozen pipeline raises no local stall.
  always_comb begin
    stallF  = 1'b0;
    bubbleE = 1'b0;
    if (!rst) begin
      if (exFlush) begin
        bubbleE = 1'b1;
      end else if (!memStall && (load_use || hilo_wait)) begin
        stallF  = 1'b1;
        bubbleE = 1'b1;
      end
    end
  end

  assign issue    = idValid & ~bubbleE & ~memStall;
  assign md_start = issue & (idIsMul | idIsDiv);

  muldiv_timer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .is_div(idIsDiv),
    .busy  (md_busy)
  );

  assign mdBusy = md_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_e    <= SHADOW_EMPTY;
      ent_m    <= SHADOW_EMPTY;
      rsFwd    <= 1'b0;
      rtFwd    <= 1'b0;
      rsFwdSel <= FWD_SEL_MEM;
      rtFwdSel <= FWD_SEL_MEM;
    end else if (!memStall) begin
      ent_m <= ent_e;
      ent_e <= issue ? '{valid: 1'b1, dest: idDest, writes: idWrites, is_load: idIsLoad}
                     : SHADOW_EMPTY;
      // The younger entry (E) shadows M, so WB is selected only without an E match.
      rsFwd    <= issue & (rs_e | rs_m);
      rtFwd    <= issue & (rt_e | rt_m);
      rsFwdSel <= (issue & ~rs_e & rs_m) ? FWD_SEL_WB : FWD_SEL_MEM;
      rtFwdSel <= (issue & ~rt_e & rt_m) ? FWD_SEL_WB : FWD_SEL_MEM;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed program fragments followed
// by random traffic, all compared against an instruction-level reference model.
module tb_hazard_scheduler;

  localparam int MULC = 4;
  localparam int DIVC = 12;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       wr;
    logic       ld;
    logic       mul;
    logic       div;
    logic       hl;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       idValid = 1'b0;
  logic [4:0] idRs = '0, idRt = '0, idDest = '0;
  logic       idUsesRs = 1'b0, idUsesRt = 1'b0, idWrites = 1'b0, idIsLoad = 1'b0;
  logic       idIsMul = 1'b0, idIsDiv = 1'b0, idReadsHiLo = 1'b0;
  logic       exFlush = 1'b0, memStall = 1'b0;
  logic       stallF, bubbleE, rsFwd, rtFwd, rsFwdSel, rtFwdSel, mdBusy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the instructions currently in EX and MEM, the remaining
  // mul/div latency, and the expected {fwd, sel} pair for each EX operand.
  instr_t     m_ex = '0;
  instr_t     m_mem = '0;
  int         m_md = 0;
  logic [1:0] m_rsf = '0;
  logic [1:0] m_rtf = '0;

  hazard_scheduler #(
    .MUL_CYCLES(MULC),
    .DIV_CYCLES(DIVC)
  ) dut (
    .clk(clk), .rst(rst), .idValid(idValid), .idRs(idRs), .idRt(idRt),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idDest(idDest), .idWrites(idWrites),
    .idIsLoad(idIsLoad), .idIsMul(idIsMul), .idIsDiv(idIsDiv), .idReadsHiLo(idReadsHiLo),
    .exFlush(exFlush), .memStall(memStall), .stallF(stallF), .bubbleE(bubbleE),
    .rsFwd(rsFwd), .rtFwd(rtFwd), .rsFwdSel(rsFwdSel), .rtFwdSel(rtFwdSel), .mdBusy(mdBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic instr_t alu(input int d, input int s, input int t);
    instr_t i = '0;
    i.v = 1'b1; i.rs = 5'(s); i.rt = 5'(t); i.urs = 1'b1; i.urt = 1'b1;
    i.dest = 5'(d); i.wr = 1'b1;
    return i;
  endfunction

  function automatic instr_t lw(input int d, input int base);
    instr_t i = '0;
    i.v = 1'b1; i.rs = 5'(base); i.urs = 1'b1; i.dest = 5'(d); i.wr = 1'b1; i.ld = 1'b1;
    return i;
  endfunction

  function automatic instr_t muldiv(input int s, input int t, input logic is_div);
    instr_t i = '0;
    i.v = 1'b1; i.rs = 5'(s); i.rt = 5'(t); i.urs = 1'b1; i.urt = 1'b1;
    i.mul = ~is_div; i.div = is_div;
    return i;
  endfunction

  function automatic instr_t mflo(input int d);
    instr_t i = '0;
    i.v = 1'b1; i.dest = 5'(d); i.wr = 1'b1; i.hl = 1'b1;
    return i;
  endfunction

  function automatic logic produces(input instr_t p, input logic [4:0] r);
    return p.v && p.wr && (p.dest == r);
  endfunction

  // Value needed by a reader: taken from the youngest in-flight producer.
  function automatic logic [1:0] fwd_code(input logic uses, input logic [4:0] r);
    if (!uses || r == 5'd0) return 2'b00;
    if (produces(m_ex, r))  return 2'b10;
    if (produces(m_mem, r)) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic needs_load_in_ex(input instr_t i);
    return m_ex.ld && ((i.urs && i.rs != 0 && produces(m_ex, i.rs)) ||
                       (i.urt && i.rt != 0 && produces(m_ex, i.rt)));
  endfunction

  task automatic cyc(input instr_t i, input logic fl, input logic ms, output logic stalled);
    logic exp_stall, exp_bub, issued;
    @(negedge clk);
    idValid = i.v; idRs = i.rs; idRt = i.rt; idUsesRs = i.urs; idUsesRt = i.urt;
    idDest = i.dest; idWrites = i.wr; idIsLoad = i.ld; idIsMul = i.mul; idIsDiv = i.div;
    idReadsHiLo = i.hl; exFlush = fl; memStall = ms;
    #1;
    exp_stall = !rst && !fl && !ms && i.v &&
                (needs_load_in_ex(i) || ((i.hl || i.mul || i.div) && m_md > 0));
    exp_bub = !rst && (fl || exp_stall);
    chk("stallF", 32'(stallF), 32'(exp_stall));
    chk("bubbleE", 32'(bubbleE), 32'(exp_bub));
    stalled = exp_stall;
    @(posedge clk);
    if (rst) begin
      m_ex = '0; m_mem = '0; m_md = 0; m_rsf = '0; m_rtf = '0;
    end else begin
      issued = i.v && !exp_bub && !ms;
      if (issued && (i.mul || i.div)) m_md = i.div ? DIVC : MULC;
      else if (m_md > 0)               m_md--;
      if (!ms) begin
        m_rsf = issued ? fwd_code(i.urs, i.rs) : 2'b00;
        m_rtf = issued ? fwd_code(i.urt, i.rt) : 2'b00;
        m_mem = m_ex;
        m_ex  = issued ? i : '0;
      end
    end
    #1;
    chk("rsFwd", 32'(rsFwd), 32'(m_rsf[1]));
    chk("rsFwdSel", 32'(rsFwdSel), 32'(m_rsf[0]));
    chk("rtFwd", 32'(rtFwd), 32'(m_rtf[1]));
    chk("rtFwdSel", 32'(rtFwdSel), 32'(m_rtf[0]));
    chk("mdBusy", 32'(mdBusy), 32'(m_md != 0));
  endtask

  // Present one instruction in ID until it leaves; reports the stall cycles seen.
  task automatic issue(input instr_t i, output int stalls);
    logic st;
    logic done = 1'b0;
    stalls = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      cyc(i, 1'b0, 1'b0, st);
      if (st) stalls++;
      else    done = 1'b1;
    end
    chk("issue_timeout", 32'(!done), 32'd0);
  endtask

  initial begin
    logic st;
    int   ns;
    instr_t r;

    rst = 1'b1;
    cyc(nop(), 1'b0, 1'b0, st);
    cyc(alu(1, 2, 3), 1'b0, 1'b0, st);
    chk("reset_rsFwd", 32'(rsFwd), 32'd0);
    chk("reset_mdBusy", 32'(mdBusy), 32'd0);
    rst = 1'b0;

    // add $1,$2,$3 ; add $4,$1,$1
    issue(alu(1, 2, 3), ns);
    issue(alu(4, 1, 1), ns);
    chk("raw_ex_stalls", 32'(ns), 32'd0);
    chk("raw_ex_rs", {30'd0, rsFwd, rsFwdSel}, 32'b10);
    chk("raw_ex_rt", {30'd0, rtFwd, rtFwdSel}, 32'b10);

    // add $1 ; nop ; sub $3,$1,$4
    issue(alu(1, 2, 3), ns);
    issue(nop(), ns);
    issue(alu(3, 1, 4), ns);
    chk("raw_mem_rs", {30'd0, rsFwd, rsFwdSel}, 32'b11);
    chk("raw_mem_rt", 32'(rtFwd), 32'd0);

    // lw $5,0($0) ; add $6,$5,$0
    issue(lw(5, 0), ns);
    issue(alu(6, 5, 0), ns);
    chk("load_use_stalls", 32'(ns), 32'd1);
    chk("load_use_rs", {30'd0, rsFwd, rsFwdSel}, 32'b11);

    // two writers to $1, then a reader: youngest wins
    issue(alu(1, 2, 3), ns);
    issue(alu(1, 3, 2), ns);
    issue(alu(7, 1, 2), ns);
    chk("youngest_rs", {30'd0, rsFwd, rsFwdSel}, 32'b10);

    // writer to $0 then reader of $0
    issue(alu(0, 2, 3), ns);
    issue(alu(8, 0, 0), ns);
    chk("zero_stalls", 32'(ns), 32'd0);
    chk("zero_fwd", {30'd0, rsFwd, rtFwd}, 32'd0);

    // mult ; mflo
    issue(muldiv(2, 3, 1'b0), ns);
    chk("mult_busy", 32'(mdBusy), 32'd1);
    issue(mflo(9), ns);
    chk("mflo_stalls", 32'(ns), 32'(MULC));
    chk("mflo_busy_done", 32'(mdBusy), 32'd0);

    // div interrupted by reset
    issue(muldiv(2, 3, 1'b1), ns);
    issue(nop(), ns);
    issue(nop(), ns);
    chk("div_busy", 32'(mdBusy), 32'd1);
    rst = 1'b1;
    cyc(mflo(9), 1'b0, 1'b0, st);
    rst = 1'b0;
    chk("div_reset_busy", 32'(mdBusy), 32'd0);
    issue(mflo(9), ns);
    chk("after_reset_stalls", 32'(ns), 32'd0);

    // load-use stall coinciding with a flush
    issue(lw(5, 0), ns);
    cyc(alu(6, 5, 0), 1'b1, 1'b0, st);
    chk("flush_fwd", {28'd0, rsFwd, rsFwdSel, rtFwd, rtFwdSel}, 32'd0);

    // memStall held three cycles: forward outputs hold
    issue(alu(1, 2, 3), ns);
    issue(alu(4, 1, 0), ns);
    for (int k = 0; k < 3; k++) begin
      cyc(alu(10, 4, 1), 1'b0, 1'b1, st);
      chk("memstall_hold", {30'd0, rsFwd, rsFwdSel}, 32'b10);
    end
    issue(alu(10, 4, 1), ns);
    chk("post_memstall_rs", {30'd0, rsFwd, rsFwdSel}, 32'b10);
    chk("post_memstall_rt", {30'd0, rtFwd, rtFwdSel}, 32'b11);

    // random traffic over a small register set
    for (int n = 0; n < 2000; n++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      case (kind)
        0:       r = nop();
        1, 2:    r = lw(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        3:       r = muldiv(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                            1'($urandom_range(0, 1)));
        4:       r = mflo(int'($urandom_range(0, 3)));
        default: r = alu(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)));
      endcase
      if ($urandom_range(0, 3) == 0) r.urt = 1'b0;
      if ($urandom_range(0, 7) == 0) r.wr = 1'b0;
      rst = ($urandom_range(0, 99) == 0);
      cyc(r, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 6) == 0), st);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
